// File: rtl/prince_affine_share_pipe.sv
// PRINCE affine share layer, forward/inverse lane map with a valid/ready register pipeline.
// Define PRINCE_AFFINE_ISO_STAGE_EN to add a second, glitch-isolation register stage.
module prince_affine_share_pipe #(
    parameter int NIBBLES   = 16,
    parameter int SHARE_ONE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic [15:0]            beat_cnt
);

    localparam int W = 4 * NIBBLES;
    localparam logic [3:0] C = (SHARE_ONE != 0) ? 4'b1011 : 4'b0000;

    function automatic logic [W-1:0] lane_map(input logic inv, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic [3:0]   x;
        logic [3:0]   y;
        logic [3:0]   z;
        r = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            x = d[4*k +: 4];
            y = '0;
            if (!inv) begin
                y[3] = C[3] ^ x[2];
                y[2] = C[2] ^ x[3] ^ x[1];
                y[1] = C[1] ^ x[2] ^ x[0];
                y[0] = C[0] ^ x[1] ^ x[0];
            end else begin
                z = x ^ C;
                y[2] = z[3];
                y[0] = z[1] ^ z[3];
                y[1] = z[0] ^ z[1] ^ z[3];
                y[3] = z[2] ^ z[0] ^ z[1] ^ z[3];
            end
            r[4*k +: 4] = y;
        end
        return r;
    endfunction

    logic           s1_valid_q, s1_valid_d;
    logic [W-1:0]   s1_data_q, s1_data_d;
    logic [15:0]    beat_cnt_q, beat_cnt_d;
    logic           s1_take;
    logic           in_fire;
    logic           out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

`ifdef PRINCE_AFFINE_ISO_STAGE_EN
    logic           s2_valid_q, s2_valid_d;
    logic [W-1:0]   s2_data_q, s2_data_d;
    logic           s1_adv;

    // Stage 1 drains into stage 2 whenever stage 2 is free or being emptied.
    assign s1_take = ~s2_valid_q | out_ready;
    assign s1_adv  = s1_valid_q & s1_take;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s1_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_adv) begin
                s2_data_d = s1_data_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
`else
    assign s1_take   = out_ready;
    assign out_valid = s1_valid_q;
    assign out_data  = s1_data_q;
`endif

    assign in_ready = ~s1_valid_q | s1_take;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_data_d = lane_map(in_inv, in_data);
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_fire) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_prince_affine_share_pipe.sv
// Bench for prince_affine_share_pipe: SHARE_ONE=1 and SHARE_ONE=0 instances on shared stimulus.
// Latency expectation follows PRINCE_AFFINE_ISO_STAGE_EN.
module tb_prince_affine_share_pipe;

`ifdef PRINCE_AFFINE_ISO_STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 16;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_inv;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         in_ready1, out_valid1, in_ready0, out_valid0;
    logic [W-1:0] out_data1, out_data0;
    logic [15:0]  beat_cnt1, beat_cnt0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    prince_affine_share_pipe #(.NIBBLES(N), .SHARE_ONE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .beat_cnt(beat_cnt1)
    );

    prince_affine_share_pipe #(.NIBBLES(N), .SHARE_ONE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .beat_cnt(beat_cnt0)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Forward lane map straight from the defining equations.
    function automatic logic [3:0] fwd4(input logic [3:0] x, input bit one);
        logic [3:0] y;
        y[3] = x[2];
        y[2] = x[3] ^ x[1];
        y[1] = x[2] ^ x[0];
        y[0] = x[1] ^ x[0];
        return y ^ (one ? 4'hB : 4'h0);
    endfunction

    // Inverse found as the preimage under the forward map.
    function automatic logic [3:0] inv4(input logic [3:0] y, input bit one);
        logic [3:0] r = 4'h0;
        for (int v = 0; v < 16; v++)
            if (fwd4(v[3:0], one) == y) r = v[3:0];
        return r;
    endfunction

    function automatic logic [W-1:0] model(input logic inv, input logic [W-1:0] d, input bit one);
        logic [W-1:0] r = '0;
        for (int k = 0; k < N; k++)
            r[4*k +: 4] = inv ? inv4(d[4*k +: 4], one) : fwd4(d[4*k +: 4], one);
        return r;
    endfunction

    // Send one beat with out_ready=1 and check the result after LAT edges.
    task automatic send(input string tag, input logic inv, input logic [W-1:0] d,
                        input logic [W-1:0] e1, input logic [W-1:0] e0);
        in_valid  = 1'b1;
        in_inv    = inv;
        in_data   = d;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        if (LAT == 2) begin
            chk({tag, "_lat_early"}, {63'b0, out_valid1}, 64'd0);
            @(posedge clk); #1;
        end
        chk({tag, "_valid"}, {63'b0, out_valid1}, 64'd1);
        chk({tag, "_s1"}, out_data1, e1);
        chk({tag, "_s0"}, out_data0, e0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] d;
    logic [W-1:0] held;
    logic         inv;
    logic         stalled;
    int           sent, got, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {63'b0, out_valid1}, 64'd0);
        chk("rst_beat_cnt", {48'b0, beat_cnt1}, 64'd0);
        chk("rst_out_data", out_data1, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready1}, 64'd1);
        @(posedge clk); #1;

        send("zero_fwd", 1'b0, 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0);
        send("f0_fwd", 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h3B3B_3B3B_3B3B_3B3B,
             model(1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0));
        send("3b_inv", 1'b1, 64'h3B3B_3B3B_3B3B_3B3B, 64'hF0F0_F0F0_F0F0_F0F0,
             model(1'b1, 64'h3B3B_3B3B_3B3B_3B3B, 1'b0));
        send("ff_fwd", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
             model(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1), 64'h8888_8888_8888_8888);
        send("88_inv", 1'b1, 64'h8888_8888_8888_8888,
             model(1'b1, 64'h8888_8888_8888_8888, 1'b1), 64'hFFFF_FFFF_FFFF_FFFF);

        // Random stream with random back-pressure, scoreboarded in order.
        do_reset();
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while ((got < 8) && (cyc < 400)) begin
            in_valid  = (sent < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_inv    = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", {63'b0, out_valid1}, 64'd1);
                chk("stall_data", out_data1, held);
            end
            if (out_valid1 && out_ready) begin
                chk("stream_s1", out_data1, (q1.size() > 0) ? q1.pop_front() : ~out_data1);
                chk("stream_s0", out_data0, (q0.size() > 0) ? q0.pop_front() : ~out_data0);
                got++;
            end
            if (in_valid && in_ready1) begin
                q1.push_back(model(in_inv, in_data, 1'b1));
                q0.push_back(model(in_inv, in_data, 1'b0));
                sent++;
            end
            stalled = out_valid1 & ~out_ready;
            held    = out_data1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_done", {32'b0, got}, 64'd8);
        chk("stream_cnt", {48'b0, beat_cnt1}, 64'd8);
        chk("stream_cnt0", {48'b0, beat_cnt0}, 64'd8);

        // Asynchronous reset while stalled with a result held.
        in_valid = 1'b1; in_inv = 1'b0; in_data = 64'h1234_5678_9ABC_DEF0; out_ready = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall_pre_rst", {63'b0, out_valid1}, 64'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'b0, out_valid1}, 64'd0);
        chk("arst_cnt", {48'b0, beat_cnt1}, 64'd0);
        chk("arst_data", out_data1, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_in_ready", {63'b0, in_ready1}, 64'd1);
        @(posedge clk); #1;

        // Wrap of beat_cnt: 65535 back-to-back beats, then one more.
        do_reset();
        in_valid = 1'b1; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("cnt_ffff", {48'b0, beat_cnt1}, 64'h0000_0000_0000_FFFF);
        send("wrap_beat", 1'b0, 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0);
        @(posedge clk); #1;
        chk("cnt_wrap", {48'b0, beat_cnt1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
